// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and helpers for the UART receiver and transmitter.
//   uart_rx_state_t : receiver FSM states, in frame order
//   uart_tx_state_t : transmitter FSM states
//   clk_per_bit()   : integer clock cycles per line bit
//   UART_DATA_BITS  : data bits per frame
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_t;

  function automatic int clk_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- 2-flop synchroniser for an asynchronous single-bit input.
//   clk, rst_n : clock, asynchronous active-low reset
//   async_i    : asynchronous input
//   sync_o     : synchronised copy, two clk cycles late
// RST_VAL sets the value both flops take in reset (1 = idle UART line).
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe_q <= {2{RST_VAL}};
    else        sync_pipe_q <= {sync_pipe_q[0], async_i};
  end

  assign sync_o = sync_pipe_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver, 8N1, LSB first, idle-high line, mid-bit sampling.
// Optional parity: define UART_RX_PARITY_EN for 8E1/8O1 (PARITY_ODD picks the sense);
// without it the frame is 8N1 and o_parity_err is constant 0.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_rx_pin      : UART line, asynchronous to clk
//   o_data        : last good byte, held until the next good frame
//   o_data_valid  : 1-cycle strobe, o_data just updated
//   o_frame_err   : 1-cycle strobe, stop bit sampled low
//   o_parity_err  : 1-cycle strobe, parity mismatch
//   o_rx_busy     : high from start-edge detect until back in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 27_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_rx_pin,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_data_valid,
  output logic                      o_frame_err,
  output logic                      o_parity_err,
  output logic                      o_rx_busy
);

  localparam int CPB   = clk_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  logic rx_s;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(i_rx_pin),
    .sync_o (rx_s)
  );

  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      perr_q, perr_d;   // parity result, consumed at stop
  logic                      brk_q, brk_d;     // frame error seen, waiting for line high
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      pstb_q, pstb_d;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    perr_d  = perr_q;
    brk_d   = brk_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    pstb_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        perr_d = 1'b0;
        brk_d  = 1'b0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Re-check at mid start bit; a high line here was only a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          perr_d  = (rx_s != ((^shift_q) ^ PAR_ODD));
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (brk_q) begin
          // Break: hold busy until the line idles so only one frame error is seen.
          if (rx_s) state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            // Leaving at mid-stop leaves half a bit to catch an abutting start bit.
            state_d = IDLE;
            if (perr_q) begin
              pstb_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      brk_q   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      pstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      brk_q   <= brk_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      pstb_q  <= pstb_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_rx_busy    = (state_q != IDLE);

`ifdef UART_RX_PARITY_EN
  assign o_parity_err = pstb_q;
`else
  assign o_parity_err = 1'b0;
  logic unused_par;
  assign unused_par = ^{pstb_q, 1'(PARITY_ODD)};
`endif

endmodule
